// File: rtl/addacc_seq.sv
// Sequencer/arbiter for one conf_buff -> t1ff -> dro_cell adder-accumulator chain.
// Optional build macro ADDACC_SEQ_PARITY_CHK_EN adds a sticky par_err output.
module addacc_seq #(
  parameter int T_SEP    = 3,
  parameter int RD_DELAY = 2,
  parameter int CLR_CYC  = 1,
  parameter int CNT_W    = 8
) (
  input  logic             clk,
  input  logic             rd,
  input  logic             a_req,
  input  logic             b_req,
  output logic             a_gnt,
  output logic             b_gnt,
  output logic             pa_out,
  output logic             pb_out,
  input  logic             rdo_req,
  output logic             dro_clk,
  output logic             t1_rd,
  input  logic             cout_in,
  input  logic             sout_in,
  output logic             result,
  output logic             rdo_done,
  output logic [CNT_W-1:0] count
`ifdef ADDACC_SEQ_PARITY_CHK_EN
  ,
  output logic             par_err
`endif
);

  localparam int SEP_W = $clog2(T_SEP + 1);
  localparam int DLY_W = $clog2(RD_DELAY + 1);
  localparam int CLR_W = $clog2(CLR_CYC + 1);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_GAP  = 3'd1;
  localparam logic [2:0] S_READ = 3'd2;
  localparam logic [2:0] S_WAIT = 3'd3;
  localparam logic [2:0] S_CLR  = 3'd4;

  logic [2:0]       state;
  logic [SEP_W-1:0] sep_cnt;
  logic [DLY_W-1:0] dly_cnt;
  logic [CLR_W-1:0] clr_cnt;
  logic             rr_b;
  logic             pick_b;

  // B wins only when alone or when the round-robin pointer favours it.
  assign pick_b = b_req & (~a_req | rr_b);

`ifndef ADDACC_SEQ_PARITY_CHK_EN
  logic unused_sout;
  assign unused_sout = sout_in;
`endif

  always_ff @(posedge clk) begin
    if (rd) begin
      state    <= S_IDLE;
      sep_cnt  <= '0;
      dly_cnt  <= '0;
      clr_cnt  <= '0;
      rr_b     <= 1'b0;
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      pa_out   <= 1'b0;
      pb_out   <= 1'b0;
      dro_clk  <= 1'b0;
      t1_rd    <= 1'b0;
      result   <= 1'b0;
      rdo_done <= 1'b0;
      count    <= '0;
`ifdef ADDACC_SEQ_PARITY_CHK_EN
      par_err  <= 1'b0;
`endif
    end else begin
      a_gnt    <= 1'b0;
      b_gnt    <= 1'b0;
      pa_out   <= 1'b0;
      pb_out   <= 1'b0;
      dro_clk  <= 1'b0;
      rdo_done <= 1'b0;
      case (state)
        S_IDLE: begin
          sep_cnt <= '0;
          dly_cnt <= '0;
          clr_cnt <= '0;
          if (rdo_req) begin
            dro_clk <= 1'b1;
            state   <= S_READ;
          end else if (a_req | b_req) begin
            a_gnt  <= ~pick_b;
            pa_out <= ~pick_b;
            b_gnt  <= pick_b;
            pb_out <= pick_b;
            rr_b   <= ~pick_b;
            count  <= count + 1'b1;
            state  <= S_GAP;
          end
        end
        // The pulse cycle itself is the first GAP cycle.
        S_GAP: begin
          if (sep_cnt == SEP_W'(T_SEP - 1)) state <= S_IDLE;
          else sep_cnt <= sep_cnt + 1'b1;
        end
        S_READ: begin
          if (dly_cnt == DLY_W'(RD_DELAY - 1)) begin
            result <= cout_in;
`ifdef ADDACC_SEQ_PARITY_CHK_EN
            if (sout_in != count[0]) par_err <= 1'b1;
`endif
            t1_rd  <= 1'b1;
            state  <= S_CLR;
          end else begin
            dly_cnt <= dly_cnt + 1'b1;
          end
        end
        S_CLR: begin
          if (clr_cnt == '0) count <= '0;
          if (clr_cnt == CLR_W'(CLR_CYC - 1)) begin
            t1_rd    <= 1'b0;
            rdo_done <= 1'b1;
            state    <= S_WAIT;
          end else begin
            clr_cnt <= clr_cnt + 1'b1;
          end
        end
        // rdo_done cycle: gives the requester a cycle to drop rdo_req.
        S_WAIT:  state <= S_IDLE;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
